// File: rtl/motor_pkg.sv
// Shared types, request decode and default parameters for the motor PWM
// H-bridge driver.
package motor_pkg;
  localparam int PWM_BITS_DEF    = 8;
  localparam int DEAD_CYCLES_DEF = 16;
  localparam int RAMP_STEP_DEF   = 32;
  localparam int DEAD_CNT_BITS   = 8;

  typedef enum logic [1:0] {OFF, RUN_FWD, RUN_REV, DEAD} chan_state_e;
  typedef enum logic [1:0] {STOP, FWD, REV} req_e;

  // Both directions at once is not a legal request and is treated as STOP.
  function automatic req_e decode_req(input logic fwd, input logic rev);
    if (fwd && !rev) return FWD;
    if (rev && !fwd) return REV;
    return STOP;
  endfunction
endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command/drive bundle between the navigation logic and the H-bridge driver.
interface motor_pwm_driver_if
  import motor_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
);
  logic                cmd_a_fwd;
  logic                cmd_a_rev;
  logic                cmd_b_fwd;
  logic                cmd_b_rev;
  logic [PWM_BITS-1:0] duty_max;
  logic                out_a_fwd;
  logic                out_a_rev;
  logic                out_b_fwd;
  logic                out_b_rev;
  logic                busy_a;
  logic                busy_b;
  logic                fault;

  modport master (
    output cmd_a_fwd, cmd_a_rev, cmd_b_fwd, cmd_b_rev, duty_max,
    input  out_a_fwd, out_a_rev, out_b_fwd, out_b_rev, busy_a, busy_b, fault
  );

  modport slave (
    input  cmd_a_fwd, cmd_a_rev, cmd_b_fwd, cmd_b_rev, duty_max,
    output out_a_fwd, out_a_rev, out_b_fwd, out_b_rev, busy_a, busy_b, fault
  );
endinterface

// File: rtl/hbridge_channel.sv
// One H-bridge channel: command decode, direction FSM with dead time,
// soft-start duty ramp and registered gate drives.
//
//   state   | meaning
//   OFF     | bridge idle, both legs low
//   RUN_FWD | forward leg PWM-driven, reverse leg low
//   RUN_REV | reverse leg PWM-driven, forward leg low
//   DEAD    | both legs low for DEAD_CYCLES before any new direction
module hbridge_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int RAMP_STEP   = RAMP_STEP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_fwd,
  input  logic                cmd_rev,
  input  logic [PWM_BITS-1:0] duty_max,
  input  logic [PWM_BITS-1:0] cnt_next,
  input  logic                wrap,
  output logic                out_fwd,
  output logic                out_rev,
  output logic                busy,
  output logic                illegal
);
  chan_state_e              state_q, state_d;
  logic [DEAD_CNT_BITS-1:0] dead_cnt_q, dead_cnt_d;
  logic [PWM_BITS-1:0]      duty_q, duty_d;
  logic                     out_fwd_q, out_fwd_d;
  logic                     out_rev_q, out_rev_d;
  logic [PWM_BITS:0]        ramp_sum;
  req_e                     req;

  assign req      = decode_req(cmd_fwd, cmd_rev);
  assign illegal  = cmd_fwd & cmd_rev;
  assign ramp_sum = {1'b0, duty_q} + (PWM_BITS+1)'(RAMP_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OFF;
      dead_cnt_q <= '0;
      duty_q     <= '0;
      out_fwd_q  <= 1'b0;
      out_rev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      duty_q     <= duty_d;
      out_fwd_q  <= out_fwd_d;
      out_rev_q  <= out_rev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    duty_d     = duty_q;
    unique case (state_q)
      OFF: begin
        if (req == FWD) begin
          state_d = RUN_FWD;
          duty_d  = '0;
        end else if (req == REV) begin
          state_d = RUN_REV;
          duty_d  = '0;
        end
      end
      RUN_FWD, RUN_REV: begin
        if ((state_q == RUN_FWD && req == FWD) || (state_q == RUN_REV && req == REV)) begin
          // Saturating ramp also pulls duty down when duty_max is lowered.
          if (wrap) begin
            duty_d = (ramp_sum > {1'b0, duty_max}) ? duty_max : ramp_sum[PWM_BITS-1:0];
          end
        end else begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_CNT_BITS'(DEAD_CYCLES - 1);
        end
      end
      DEAD: begin
        if (dead_cnt_q == '0) begin
          duty_d = '0;
          if (req == FWD)      state_d = RUN_FWD;
          else if (req == REV) state_d = RUN_REV;
          else                 state_d = OFF;
        end else begin
          dead_cnt_d = dead_cnt_q - DEAD_CNT_BITS'(1);
        end
      end
      default: state_d = OFF;
    endcase
    // Drives are computed from the next state and next count so the
    // registered legs line up with the state they belong to.
    out_fwd_d = (state_d == RUN_FWD) && (cnt_next < duty_d);
    out_rev_d = (state_d == RUN_REV) && (cnt_next < duty_d);
  end

  assign out_fwd = out_fwd_q;
  assign out_rev = out_rev_q;
  assign busy    = (state_q == DEAD);
endmodule

// File: rtl/motor_pwm_driver.sv
// Two-channel motor PWM driver: shared PWM counter and sticky fault flag
// around two independent H-bridge channels.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int RAMP_STEP   = RAMP_STEP_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  motor_pwm_driver_if.slave        bus
);
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic                wrap;
  logic                illegal_a, illegal_b;

  assign wrap = (cnt_q == '1);

  always_comb begin
    cnt_d   = cnt_q + PWM_BITS'(1);
    fault_d = fault_q | illegal_a | illegal_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  hbridge_channel #(
    .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP)
  ) u_chan_a (
    .clk(clk), .reset(reset),
    .cmd_fwd(bus.cmd_a_fwd), .cmd_rev(bus.cmd_a_rev),
    .duty_max(bus.duty_max), .cnt_next(cnt_d), .wrap(wrap),
    .out_fwd(bus.out_a_fwd), .out_rev(bus.out_a_rev),
    .busy(bus.busy_a), .illegal(illegal_a)
  );

  hbridge_channel #(
    .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP)
  ) u_chan_b (
    .clk(clk), .reset(reset),
    .cmd_fwd(bus.cmd_b_fwd), .cmd_rev(bus.cmd_b_rev),
    .duty_max(bus.duty_max), .cnt_next(cnt_d), .wrap(wrap),
    .out_fwd(bus.out_b_fwd), .out_rev(bus.out_b_rev),
    .busy(bus.busy_b), .illegal(illegal_b)
  );

  assign bus.fault = fault_q;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_motor_pwm_driver;
  localparam int PW = 8;
  localparam int DC = 16;
  localparam int RS = 32;
  localparam int PERIOD = 256;
  localparam int M_OFF = 0, M_FWD = 1, M_REV = 2, M_DEAD = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motor_pwm_driver_if #(.PWM_BITS(PW)) bus();

  motor_pwm_driver #(.PWM_BITS(PW), .DEAD_CYCLES(DC), .RAMP_STEP(RS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode per channel, cycles left in dead time, duty.
  int m_cnt;
  int m_mode[2];
  int m_dleft[2];
  int m_duty[2];
  bit m_fault;
  bit m_valid = 1'b0;
  int m_rq;
  bit m_wrapped;
  bit m_f, m_r;

  function automatic int req_of(input bit f, input bit r);
    if (f && !r) return M_FWD;
    if (r && !f) return M_REV;
    return M_OFF;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      m_fault = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_mode[ch] = M_OFF;
        m_dleft[ch] = 0;
        m_duty[ch] = 0;
      end
      m_valid = 1'b1;
    end else begin
      m_wrapped = (m_cnt == PERIOD - 1);
      for (int ch = 0; ch < 2; ch++) begin
        m_f = (ch == 0) ? bus.cmd_a_fwd : bus.cmd_b_fwd;
        m_r = (ch == 0) ? bus.cmd_a_rev : bus.cmd_b_rev;
        m_rq = req_of(m_f, m_r);
        if (m_f && m_r) m_fault = 1'b1;
        case (m_mode[ch])
          M_OFF: if (m_rq != M_OFF) begin
            m_mode[ch] = m_rq;
            m_duty[ch] = 0;
          end
          M_FWD, M_REV: begin
            if (m_rq == m_mode[ch]) begin
              if (m_wrapped)
                m_duty[ch] = (m_duty[ch] + RS > int'(bus.duty_max)) ? int'(bus.duty_max)
                                                                     : m_duty[ch] + RS;
            end else begin
              m_mode[ch] = M_DEAD;
              m_dleft[ch] = DC;
            end
          end
          default: begin
            m_dleft[ch] = m_dleft[ch] - 1;
            if (m_dleft[ch] == 0) begin
              m_mode[ch] = m_rq;
              m_duty[ch] = 0;
            end
          end
        endcase
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("out_a_fwd", int'(bus.out_a_fwd), int'(m_mode[0] == M_FWD && m_cnt < m_duty[0]));
      check("out_a_rev", int'(bus.out_a_rev), int'(m_mode[0] == M_REV && m_cnt < m_duty[0]));
      check("out_b_fwd", int'(bus.out_b_fwd), int'(m_mode[1] == M_FWD && m_cnt < m_duty[1]));
      check("out_b_rev", int'(bus.out_b_rev), int'(m_mode[1] == M_REV && m_cnt < m_duty[1]));
      check("busy_a", int'(bus.busy_a), int'(m_mode[0] == M_DEAD));
      check("busy_b", int'(bus.busy_b), int'(m_mode[1] == M_DEAD));
      check("fault", int'(bus.fault), int'(m_fault));
      check("a_legs_exclusive", int'(bus.out_a_fwd & bus.out_a_rev), 0);
    end
  end

  task automatic set_a(input bit f, input bit r);
    bus.cmd_a_fwd = f;
    bus.cmd_a_rev = r;
  endtask

  task automatic set_b(input bit f, input bit r);
    bus.cmd_b_fwd = f;
    bus.cmd_b_rev = r;
  endtask

  task automatic count_highs(input int n, output int hf, output int hr);
    hf = 0;
    hr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.out_a_fwd) hf++;
      if (bus.out_a_rev) hr++;
    end
  endtask

  // Leaves the bench at the sample where the counter shows all-ones.
  task automatic align();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_cnt != PERIOD - 1 && k < 400);
    check("align_bound", int'(k < 400), 1);
  endtask

  int ramp_exp[5] = '{32, 64, 96, 128, 128};
  int hf, hr, n;

  initial begin
    reset = 1'b1;
    set_a(0, 0);
    set_b(0, 0);
    bus.duty_max = '0;
    repeat (3) @(negedge clk);
    check("rst_out_a_fwd", int'(bus.out_a_fwd), 0);
    check("rst_busy_a", int'(bus.busy_a), 0);
    check("rst_fault", int'(bus.fault), 0);

    // Soft-start from reset release.
    bus.duty_max = 8'd128;
    set_a(1, 0);
    reset = 1'b0;
    count_highs(PERIOD - 1, hf, hr);
    check("ramp_p0_fwd", hf, 0);
    check("ramp_p0_rev", hr, 0);
    for (int i = 0; i < 5; i++) begin
      count_highs(PERIOD, hf, hr);
      check("ramp_fwd", hf, ramp_exp[i]);
      check("ramp_rev", hr, 0);
    end

    // Direction reversal through dead time.
    set_a(0, 1);
    @(negedge clk);
    check("rev_dead_fwd_low", int'(bus.out_a_fwd), 0);
    n = 0;
    while (bus.busy_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("dead_len_rev", n, DC);
    align();
    count_highs(PERIOD, hf, hr);
    check("rev_first_period", hr, 32);

    // Illegal command on B while running forward.
    set_b(1, 0);
    repeat (300) @(negedge clk);
    set_b(1, 1);
    @(negedge clk);
    check("illegal_b_fwd", int'(bus.out_b_fwd), 0);
    check("illegal_b_rev", int'(bus.out_b_rev), 0);
    check("illegal_fault", int'(bus.fault), 1);
    set_b(0, 0);
    repeat (50) @(negedge clk);
    check("fault_sticky", int'(bus.fault), 1);

    // Duty limits.
    bus.duty_max = 8'd0;
    align();
    count_highs(PERIOD, hf, hr);
    check("duty0_rev", hr, 0);
    bus.duty_max = 8'd255;
    repeat (9 * PERIOD) @(negedge clk);
    align();
    count_highs(PERIOD, hf, hr);
    check("duty255_rev", hr, 255);
    check("duty255_fwd", hf, 0);

    // Request toggling inside dead time does not restart it.
    set_a(0, 0);
    @(negedge clk);
    n = 0;
    while (bus.busy_a && n < 100) begin
      n++;
      if (n == 3) set_a(1, 0);
      if (n == 9) set_a(0, 1);
      @(negedge clk);
    end
    check("dead_len_toggle", n, DC);
    align();
    count_highs(PERIOD, hf, hr);
    check("toggle_exit_rev", hr, 32);
    check("toggle_exit_fwd", hf, 0);

    // Reset in the middle of dead time.
    set_a(1, 0);
    @(negedge clk);
    n = 1;
    while (bus.busy_a && n < 5) begin
      n++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out_a_fwd", int'(bus.out_a_fwd), 0);
    check("midreset_out_a_rev", int'(bus.out_a_rev), 0);
    check("midreset_busy_a", int'(bus.busy_a), 0);
    check("midreset_fault", int'(bus.fault), 0);
    reset = 1'b0;
    count_highs(PERIOD - 1, hf, hr);
    check("post_reset_p0", hf, 0);
    count_highs(PERIOD, hf, hr);
    check("post_reset_p1", hf, 32);
    check("post_reset_rev", hr, 0);

    // Random traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int sa, sb;
      sa = $urandom_range(0, 9);
      sb = $urandom_range(0, 9);
      set_a(sa inside {[1:4]} || sa == 9, sa inside {[5:8]} || sa == 9);
      set_b(sb inside {[1:4]} || sb == 9, sb inside {[5:8]} || sb == 9);
      if ($urandom_range(0, 3) == 0) bus.duty_max = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(1, 600)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the PWM counter and of the duty values.
REQ-002 Parameter DEAD_CYCLES, default 16: clock cycles both bridge legs are held low on any exit from run (range 1..255).
REQ-003 Parameter RAMP_STEP, default 32: duty increment applied per PWM period during soft-start.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_a_fwd, cmd_a_rev  in  1 each  motor A direction request from the navigation FSM.
REQ-007 cmd_b_fwd, cmd_b_rev  in  1 each  motor B direction request.
REQ-008 duty_max  in  PWM_BITS  target duty shared by both channels.
REQ-009 out_a_fwd, out_a_rev, out_b_fwd, out_b_rev  out  1 each  registered H-bridge gate drives.
REQ-010 busy_a, busy_b  out  1 each  high while the channel is in DEAD.
REQ-011 fault  out  1  sticky flag for an illegal command.

Function
REQ-012 The shared counter cnt SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0; wrap = (cnt == all-ones).
REQ-013 Per-channel command decode SHALL be:
  - fwd only -> FWD
  - rev only -> REV
  - neither -> STOP
  - both -> STOP, and fault SHALL be set on the same edge.
REQ-014 Each channel SHALL implement the states OFF, RUN_FWD, RUN_REV and DEAD.
REQ-015 OFF SHALL go to RUN_FWD or RUN_REV on a FWD or REV request, and SHALL stay in OFF on STOP.
REQ-016 RUN_x SHALL stay in RUN_x while request x holds.
REQ-017 RUN_x SHALL go to DEAD on an opposite or STOP request, loading dead_cnt = DEAD_CYCLES-1.
REQ-018 DEAD SHALL decrement dead_cnt every cycle.
REQ-019 DEAD SHALL exit when dead_cnt = 0:
  - to RUN_FWD or RUN_REV per the request sampled in that cycle
  - to OFF on STOP.
REQ-020 A request change during DEAD SHALL NOT reload dead_cnt.
REQ-021 Entering any RUN state SHALL clear duty_cur to 0.
REQ-022 In RUN, at each wrap, duty_cur SHALL become min(duty_cur + RAMP_STEP, duty_max).
REQ-023 The ramp addition SHALL use PWM_BITS+1 bits so that it saturates without overflow.
REQ-024 If duty_max falls below duty_cur, duty_cur SHALL take the value duty_max at the next wrap.
REQ-025 The active leg SHALL be driven high iff (cnt < duty_cur) while in the matching RUN state; the other leg SHALL be low.
REQ-026 duty_cur = 0 SHALL drive the leg low continuously; duty_cur = all-ones SHALL give 2^PWM_BITS-1 high cycles per period.
REQ-027 Both legs SHALL be low in OFF and DEAD.
REQ-028 Output registers SHALL be updated on the same edge as the state register, so outputs reflect the state entered on that edge.
REQ-029 The xxx_fwd and xxx_rev outputs of one channel SHALL never be high in the same cycle, including at every state transition.
REQ-030 Channels A and B SHALL operate independently and share only cnt and fault.

Reset
REQ-031 While reset is high:
  - all outputs SHALL be 0
  - cnt, duty_cur and dead_cnt SHALL be 0
  - both channels SHALL be in OFF
  - fault SHALL be 0.
REQ-032 Reset SHALL override any state, including DEAD mid-count; the first cycle after release SHALL start from OFF.
REQ-033 fault SHALL clear only on reset.

Structure
REQ-034 Package motor_pkg SHALL hold:
  - the channel state enum (OFF, RUN_FWD, RUN_REV, DEAD)
  - the request enum (STOP, FWD, REV)
  - the default parameter constants.
REQ-035 Sub-module hbridge_channel SHALL contain the decode, state machine, dead counter, ramp and output registers for one channel.
REQ-036 The top SHALL instantiate hbridge_channel twice and hold cnt and fault.

Verification (PWM_BITS=8, DEAD_CYCLES=16, RAMP_STEP=32)
REQ-037 Reset release, cmd_a_fwd=1, duty_max=128 -> out_a_fwd high-cycles per 256-cycle period = 0, 32, 64, 96, 128, 128...; out_a_rev=0 throughout.
REQ-038 RUN_FWD steady, then request switched to REV -> next edge both A outputs low and busy_a=1 for exactly 16 cycles, then out_a_rev ramps from 0.
REQ-039 cmd_b_fwd=cmd_b_rev=1 while in RUN_FWD -> B outputs low from the next edge and fault=1; fault stays 1 after the command clears, until reset.
REQ-040 duty_max=0 -> leg never high; duty_max=255 after ramp -> 255 high cycles per 256.
REQ-041 REV->FWD->REV toggled at DEAD cycles 3 and 9 -> DEAD still lasts 16 cycles and exits to RUN_REV.
REQ-042 reset asserted at DEAD cycle 5 -> next edge all outputs 0, busy 0, fault 0; after release with FWD held -> RUN_FWD with ramp from 0.
